// File: rtl/cgra_config_loader_if.sv
// Config-word stream between a host/DMA source and the CGRA config loader.
// The master drives a word plus valid/last, and the slave returns ready.
interface cgra_config_loader_if #(
  parameter int unsigned PE_ROW_BIT_LENGTH       = 2,
  parameter int unsigned PE_COLUMN_BIT_LENGTH    = 2,
  parameter int unsigned NEIGHBOR_PE_NUM         = 4,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned OPERATION_BIT_LENGTH    = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 5
);
  logic                               in_valid;
  logic                               in_ready;
  logic                               in_last;
  logic [PE_ROW_BIT_LENGTH-1:0]       in_row;
  logic [PE_COLUMN_BIT_LENGTH-1:0]    in_column;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] in_context;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_input_2;
  logic [NEIGHBOR_PE_NUM-1:0]         in_output_mask;
  logic [OPERATION_BIT_LENGTH-1:0]    in_op;
  logic [DATA_WIDTH-1:0]              in_const;

  modport master (
    output in_valid, in_last, in_row, in_column, in_context, in_input_1, in_input_2,
           in_output_mask, in_op, in_const,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_row, in_column, in_context, in_input_1, in_input_2,
           in_output_mask, in_op, in_const,
    output in_ready
  );
endinterface

// File: rtl/cgra_config_loader.sv
// CGRA config loader: accepts a stream of per-PE/per-context config words and replays them
// as one registered write strobe per word, then signals start of execution at end of session.
module cgra_config_loader #(
  parameter int unsigned PE_ROW_SIZE             = 4,
  parameter int unsigned PE_COLUMN_SIZE          = 4,
  parameter int unsigned PE_ROW_BIT_LENGTH       = 2,
  parameter int unsigned PE_COLUMN_BIT_LENGTH    = 2,
  parameter int unsigned NEIGHBOR_PE_NUM         = 4,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned OPERATION_BIT_LENGTH    = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load_start,
  cgra_config_loader_if.slave                cfg,
  output logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic                               write_config_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               start_exec,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [15:0]                        word_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StStart} state_e;

  state_e state_q, state_d;
  logic   accept, in_range, wr_en, session_start;
  logic   error_q, done_q, write_q;
  logic [15:0]                        count_q;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q;

  assign cfg.in_ready  = (state_q == StLoad);
  assign accept        = cfg.in_valid && cfg.in_ready;
  // Casts widen the indices so the range check also works when the index can exceed the array.
  assign in_range      = (int'(cfg.in_row) < int'(PE_ROW_SIZE)) &&
                         (int'(cfg.in_column) < int'(PE_COLUMN_SIZE));
  assign wr_en         = accept && in_range;
  assign session_start = (state_q == StIdle) && load_start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; a rejected last word still closes the session.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_start) state_d = StLoad;
      StLoad:  if (accept && cfg.in_last) state_d = StFlush;
      StFlush: state_d = StStart;
      StStart: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered config fields: updated only on written words, held between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      config_PE_row_index     <= '0;
      config_PE_column_index  <= '0;
      config_input_PE_index_1 <= '0;
      config_input_PE_index_2 <= '0;
      config_output_PE_index  <= '0;
      config_op               <= '0;
      config_const_data       <= '0;
      config_index            <= '0;
    end else if (wr_en) begin
      config_PE_row_index     <= cfg.in_row;
      config_PE_column_index  <= cfg.in_column;
      config_input_PE_index_1 <= cfg.in_input_1;
      config_input_PE_index_2 <= cfg.in_input_2;
      config_output_PE_index  <= cfg.in_output_mask;
      config_op               <= cfg.in_op;
      config_const_data       <= cfg.in_const;
      config_index            <= cfg.in_context;
    end
  end

  // Session status: strobe, saturating count, max context, sticky error/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      count_q  <= '0;
      max_id_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      write_q <= wr_en;
      if (session_start) begin
        count_q  <= '0;
        max_id_q <= '0;
        error_q  <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        if (wr_en && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
        if (wr_en && (cfg.in_context > max_id_q)) max_id_q <= cfg.in_context;
        if (accept && !in_range) error_q <= 1'b1;
        if (state_q == StStart) done_q <= 1'b1;
      end
    end
  end

  assign write_config_data      = write_q;
  assign word_count             = count_q;
  assign mapping_context_max_id = max_id_q;
  assign error                  = error_q;
  assign done                   = done_q;
  assign busy                   = (state_q != StIdle);
  assign start_exec             = (state_q == StStart) && !error_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader. Indices are widened to 3 bits so out-of-range rows
// (row = 4 with a 4-row array) can be presented.
module tb_cgra_config_loader;
  localparam int unsigned RB = 3;
  localparam int unsigned CB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_start = 1'b0;

  logic [RB-1:0]  row_idx;
  logic [CB-1:0]  col_idx;
  logic [2:0]     in1_idx, in2_idx;
  logic [3:0]     out_idx, op;
  logic [31:0]    cdata;
  logic [4:0]     cidx, max_id;
  logic           wr, start_exec, busy, done, error;
  logic [15:0]    word_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cgra_config_loader_if #(.PE_ROW_BIT_LENGTH(RB), .PE_COLUMN_BIT_LENGTH(CB)) bus ();

  cgra_config_loader #(
    .PE_ROW_SIZE(4), .PE_COLUMN_SIZE(4),
    .PE_ROW_BIT_LENGTH(RB), .PE_COLUMN_BIT_LENGTH(CB)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .load_start              (load_start),
    .cfg                     (bus),
    .config_PE_row_index     (row_idx),
    .config_PE_column_index  (col_idx),
    .config_input_PE_index_1 (in1_idx),
    .config_input_PE_index_2 (in2_idx),
    .config_output_PE_index  (out_idx),
    .config_op               (op),
    .config_const_data       (cdata),
    .config_index            (cidx),
    .write_config_data       (wr),
    .mapping_context_max_id  (max_id),
    .start_exec              (start_exec),
    .busy                    (busy),
    .done                    (done),
    .error                   (error),
    .word_count              (word_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic v, input logic last, input logic [RB-1:0] r,
                      input logic [CB-1:0] c, input logic [4:0] ctx);
    bus.in_valid       = v;
    bus.in_last        = last;
    bus.in_row         = r;
    bus.in_column      = c;
    bus.in_context     = ctx;
    bus.in_input_1     = 3'(ctx + 5'd1);
    bus.in_input_2     = 3'(ctx + 5'd2);
    bus.in_output_mask = 4'(ctx);
    bus.in_op          = 4'(r + 3'd7);
    bus.in_const       = {27'h0, ctx} ^ 32'hA5A5_0000;
  endtask

  task automatic idle_bus();
    word(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    idle_bus();
    repeat (3) tick();
    // Reset state
    check("rst_write", 32'(wr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(bus.in_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(word_count), 0);
    check("rst_start", 32'(start_exec), 0);
    reset = 1'b0;
    tick();

    // T1: three back-to-back words
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    check("t1_ready", 32'(bus.in_ready), 1);
    word(1'b1, 1'b0, 3'd0, 3'd0, 5'd0);
    tick();
    check("t1_w0_strobe", 32'(wr), 1);
    check("t1_w0_row", 32'(row_idx), 0);
    check("t1_w0_idx", 32'(cidx), 0);
    word(1'b1, 1'b0, 3'd1, 3'd2, 5'd3);
    tick();
    check("t1_w1_strobe", 32'(wr), 1);
    check("t1_w1_row", 32'(row_idx), 1);
    check("t1_w1_col", 32'(col_idx), 2);
    check("t1_w1_idx", 32'(cidx), 3);
    check("t1_w1_in1", 32'(in1_idx), 4);
    check("t1_w1_in2", 32'(in2_idx), 5);
    check("t1_w1_mask", 32'(out_idx), 3);
    check("t1_w1_op", 32'(op), 8);
    check("t1_w1_const", cdata, 32'hA5A5_0003);
    word(1'b1, 1'b1, 3'd3, 3'd3, 5'd1);
    tick();
    idle_bus();
    check("t1_w2_strobe", 32'(wr), 1);
    check("t1_w2_row", 32'(row_idx), 3);
    check("t1_w2_col", 32'(col_idx), 3);
    check("t1_flush_ready", 32'(bus.in_ready), 0);
    check("t1_flush_start", 32'(start_exec), 0);
    tick();
    check("t1_start", 32'(start_exec), 1);
    check("t1_no_strobe", 32'(wr), 0);
    check("t1_max", 32'(max_id), 3);
    check("t1_count", 32'(word_count), 3);
    tick();
    check("t1_done", 32'(done), 1);
    check("t1_idle", 32'(busy), 0);
    check("t1_start_end", 32'(start_exec), 0);

    // T2: valid toggled while idle is ignored
    for (int i = 0; i < 3; i++) begin
      word((i != 1), 1'b0, 3'd2, 3'd2, 5'd9);
      tick();
      check("t2_ready", 32'(bus.in_ready), 0);
      check("t2_strobe", 32'(wr), 0);
    end
    idle_bus();
    check("t2_count", 32'(word_count), 3);

    // T3: out-of-range row between two good words
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t3_done_clr", 32'(done), 0);
    check("t3_count_clr", 32'(word_count), 0);
    check("t3_max_clr", 32'(max_id), 0);
    word(1'b1, 1'b0, 3'd1, 3'd1, 5'd2);
    tick();
    check("t3_a_strobe", 32'(wr), 1);
    word(1'b1, 1'b0, 3'd4, 3'd0, 5'd7);
    tick();
    check("t3_bad_strobe", 32'(wr), 0);
    check("t3_bad_error", 32'(error), 1);
    check("t3_bad_hold_row", 32'(row_idx), 1);
    check("t3_bad_hold_idx", 32'(cidx), 2);
    word(1'b1, 1'b1, 3'd2, 3'd0, 5'd5);
    tick();
    idle_bus();
    check("t3_c_strobe", 32'(wr), 1);
    check("t3_c_row", 32'(row_idx), 2);
    tick();
    check("t3_no_start", 32'(start_exec), 0);
    check("t3_busy_start", 32'(busy), 1);
    check("t3_count", 32'(word_count), 2);
    check("t3_max", 32'(max_id), 5);
    tick();
    check("t3_done", 32'(done), 1);
    check("t3_error", 32'(error), 1);
    check("t3_idle", 32'(busy), 0);

    // T4: reset mid-session
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word(1'b1, 1'b0, 3'd1, 3'd0, 5'd4);
    tick();
    word(1'b1, 1'b0, 3'd2, 3'd1, 5'd6);
    tick();
    check("t4_w1_strobe", 32'(wr), 1);
    check("t4_w1_count", 32'(word_count), 2);
    reset = 1'b1;
    tick();
    check("t4_rst_strobe", 32'(wr), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_count", 32'(word_count), 0);
    check("t4_rst_row", 32'(row_idx), 0);
    check("t4_rst_error", 32'(error), 0);
    check("t4_rst_done", 32'(done), 0);
    check("t4_rst_max", 32'(max_id), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_post_strobe", 32'(wr), 0);
      check("t4_post_start", 32'(start_exec), 0);
    end
    idle_bus();

    // T5: load_start during LOAD ignored; after done it restarts the session
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word(1'b1, 1'b0, 3'd1, 3'd1, 5'd4);
    tick();
    idle_bus();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t5_still_load", 32'(bus.in_ready), 1);
    check("t5_count_kept", 32'(word_count), 1);
    check("t5_max_kept", 32'(max_id), 4);
    word(1'b1, 1'b1, 3'd0, 3'd1, 5'd2);
    tick();
    idle_bus();
    tick();
    check("t5_start", 32'(start_exec), 1);
    check("t5_count", 32'(word_count), 2);
    check("t5_max", 32'(max_id), 4);
    tick();
    check("t5_done", 32'(done), 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t5_restart_done", 32'(done), 0);
    check("t5_restart_count", 32'(word_count), 0);
    check("t5_restart_max", 32'(max_id), 0);
    check("t5_restart_busy", 32'(busy), 1);

    // T6: single last word with context 31
    word(1'b1, 1'b1, 3'd2, 3'd3, 5'd31);
    tick();
    idle_bus();
    check("t6_strobe", 32'(wr), 1);
    check("t6_idx", 32'(cidx), 31);
    check("t6_max", 32'(max_id), 31);
    check("t6_count", 32'(word_count), 1);
    check("t6_flush_start", 32'(start_exec), 0);
    tick();
    check("t6_start", 32'(start_exec), 1);
    check("t6_busy_start", 32'(busy), 1);
    tick();
    check("t6_idle", 32'(busy), 0);
    check("t6_done", 32'(done), 1);
    check("t6_start_end", 32'(start_exec), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
